// File: rtl/fpga_ram_pkg.sv
// -----------------------------------------------------------------------------
// fpga_ram_pkg
//
// Purpose: shared definitions for the N-read/1-write distributed-RAM register
// file (fpga_ram_nr1w_init) and its single-bank leaf (fpga_ram_1r1w).
//
// Contents:
//   ram_state_e  - clear-sweep controller state (RAM_INIT, RAM_RUN)
//   calc_addr_w  - address width for a given depth, never less than 1 bit
// -----------------------------------------------------------------------------
package fpga_ram_pkg;

  // RAM_INIT: hardware clear sweep in progress, array contents not yet valid.
  // RAM_RUN : normal operation, external write port live.
  typedef enum logic {
    RAM_INIT = 1'b0,
    RAM_RUN  = 1'b1
  } ram_state_e;

  // $clog2 returns 0 for a depth of 1; the floor keeps every address bus at
  // least one bit wide so port slicing never collapses to a zero-width range.
  function automatic int calc_addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fpga_ram_1r1w.sv
// -----------------------------------------------------------------------------
// fpga_ram_1r1w
//
// Purpose: one LUTRAM bank with a single synchronous write port and a single
// asynchronous read port. No reset: contents are cleared by the sweep in the
// parent, which keeps this mappable onto distributed RAM primitives.
//
// Parameters:
//   WIDTH   - data bits per entry
//   DEPTH   - number of entries
//   ADDR_W  - address width (supplied by the parent)
//
// Ports:
//   clk_i    in   write clock, rising edge
//   we_i     in   write enable
//   waddr_i  in   write address (parent guarantees waddr_i < DEPTH when we_i)
//   wdata_i  in   write data
//   raddr_i  in   read address (parent masks the result when >= DEPTH)
//   rdata_o  out  asynchronous read data, mem[raddr_i]
// -----------------------------------------------------------------------------
module fpga_ram_1r1w #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Combinational read: this is what makes the array LUTRAM rather than
  // block RAM. Out-of-range addresses are zeroed by the parent.
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fpga_ram_nr1w_init.sv
// -----------------------------------------------------------------------------
// fpga_ram_nr1w_init
//
// Purpose: parametrised N-read/1-write distributed-RAM register file with a
// post-reset hardware clear sweep. Each read port owns a replicated LUTRAM
// bank; all banks receive the same writes, so every port sees identical
// contents. While the sweep runs, external writes are dropped and all read
// ports return 0; ready_o rises once every entry has been cleared.
//
// Optional feature (macro FPGA_RAM_BYPASS_EN): same-cycle write-to-read
// forwarding. When defined, a read port whose address matches an accepted
// external write returns the write data in that same cycle. When undefined,
// the port returns the pre-write contents. Forwarding never applies during
// the sweep.
//
// Parameters:
//   WIDTH   - data bits per entry (>= 1)
//   DEPTH   - number of entries (>= 2, need not be a power of two)
//   NRD     - number of read ports (>= 1)
//   ADDR_W  - address width, derived from DEPTH; leave at its default
//
// Ports:
//   clk_i    in   sole clock, all state updates on the rising edge
//   rst_i    in   synchronous active-high reset; restarts the clear sweep
//   raddr_i  in   NRD*ADDR_W read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rdata_o  out  NRD*WIDTH asynchronous read data, port i at [i*WIDTH +: WIDTH]
//   waddr_i  in   write address
//   wdata_i  in   write data
//   we_i     in   write enable
//   ready_o  out  high once the clear sweep has completed
// -----------------------------------------------------------------------------
module fpga_ram_nr1w_init
  import fpga_ram_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int NRD    = 3,
  parameter int ADDR_W = calc_addr_w(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NRD*ADDR_W-1:0] raddr_i,
  output logic [NRD*WIDTH-1:0]  rdata_o,
  input  logic [ADDR_W-1:0]     waddr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic                  we_i,
  output logic                  ready_o
);

  // One extra bit so DEPTH itself is representable for range compares, even
  // when DEPTH is an exact power of two.
  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  // ---------------------------------------------------------------------------
  // Clear-sweep controller
  // ---------------------------------------------------------------------------
  ram_state_e        state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              run;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= RAM_INIT;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      RAM_INIT: begin
        if (clr_cnt_q == LAST_ADDR) begin
          // Final entry is being cleared on this edge; RUN is the only exit.
          state_d   = RAM_RUN;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      RAM_RUN: begin
        state_d   = RAM_RUN;
      end
      default: begin
        state_d   = RAM_INIT;
        clr_cnt_d = '0;
      end
    endcase
  end

  assign run     = (state_q == RAM_RUN);
  assign ready_o = run;

  // ---------------------------------------------------------------------------
  // Write port mux: sweep owns the banks in INIT, external port in RUN.
  // ---------------------------------------------------------------------------
  logic              waddr_ok;
  logic              ext_we;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [WIDTH-1:0]  mem_wdata;

  assign waddr_ok = ({1'b0, waddr_i} < DEPTH_X);

  // An external write is accepted only in RUN, in range, and not on a reset
  // edge, so nothing written by the user survives into the restarted sweep.
  assign ext_we = run & we_i & waddr_ok & ~rst_i;

  always_comb begin
    mem_we    = ext_we;
    mem_waddr = waddr_i;
    mem_wdata = wdata_i;
    if (!run) begin
      mem_we    = 1'b1;
      mem_waddr = clr_cnt_q;
      mem_wdata = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports: one replicated bank each, plus range check, optional
  // forwarding and forcing to zero outside RUN.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NRD; gi++) begin : g_port
    logic [ADDR_W-1:0] port_raddr;
    logic [WIDTH-1:0]  bank_rdata;
    logic [WIDTH-1:0]  port_rdata;
    logic              raddr_ok;
    logic              fwd_hit;

    assign port_raddr = raddr_i[gi*ADDR_W +: ADDR_W];
    assign raddr_ok   = ({1'b0, port_raddr} < DEPTH_X);

    fpga_ram_1r1w #(
      .WIDTH  (WIDTH),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
    ) u_bank (
      .clk_i   (clk_i),
      .we_i    (mem_we),
      .waddr_i (mem_waddr),
      .wdata_i (mem_wdata),
      .raddr_i (port_raddr),
      .rdata_o (bank_rdata)
    );

`ifdef FPGA_RAM_BYPASS_EN
    // ext_we already implies RUN and an in-range write address, so a match
    // here can only forward data that is genuinely being committed.
    assign fwd_hit = ext_we & (port_raddr == waddr_i);
`else
    assign fwd_hit = 1'b0;
`endif

    always_comb begin
      port_rdata = '0;
      if (run && raddr_ok) begin
        port_rdata = fwd_hit ? wdata_i : bank_rdata;
      end
    end

    assign rdata_o[gi*WIDTH +: WIDTH] = port_rdata;
  end

endmodule

// File: doc/fpga_ram_nr1w_init.md
# fpga_ram_nr1w_init

Parametrised distributed-RAM register file for FPGA builds, generalising the fixed 3-read/1-write 32-entry LUTRAM array to arbitrary width, depth and read-port count. It adds a post-reset hardware clear sweep with a ready flag, and optional same-cycle write-to-read forwarding. It sits under the register-file and rename-table wrappers wherever an N-read/1-write asynchronous-read array is needed, and it is FPGA only.

## Interface
- WIDTH, 32, data bits per entry (any value ≥1)
- DEPTH, 32, number of entries (≥2, need not be a power of two)
- NRD, 3, number of read ports (≥1)
- ADDR_W, $clog2(DEPTH), address width (derived; do not override)
- clk  in  1  sole clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- raddr  in  NRD*ADDR_W  read addresses, port i at [i*ADDR_W +: ADDR_W]
- rdata  out  NRD*WIDTH  asynchronous read data, port i at [i*WIDTH +: WIDTH]
- waddr  in  ADDR_W  write address
- wdata  in  WIDTH  write data
- we  in  1  write enable
- ready  out  1  high once the clear sweep has completed; array contents are valid

## Operation
- State machine, two states: INIT and RUN.
  - rst=1 forces INIT and clr_cnt=0.
  - In INIT, each cycle writes 0 to entry clr_cnt, then clr_cnt increments.
  - When clr_cnt==DEPTH-1 is written, the state goes to RUN. There is no other exit.
- ready is 1 exactly in RUN.
- In INIT:
  - External we is ignored; the write is dropped, not queued.
  - All rdata ports are forced to 0.
- In RUN:
  - we=1 with waddr<DEPTH writes wdata to mem[waddr] at the rising edge.
  - we=1 with waddr≥DEPTH is ignored.
- Reads are combinational: rdata[i] = mem[raddr[i]].
  - raddr[i]≥DEPTH returns 0.
  - Ports are independent. Any combination of equal addresses is legal.
- Reset mid-sweep or in RUN restarts the sweep from entry 0. No write is in flight across reset.
- Storage is one 1W1R LUTRAM bank per read port, all written identically. This is replication, not banking, so every port sees identical contents.

## Timing
- Reset values: ready=0, rdata=0 (forced by INIT), clr_cnt=0, state=INIT.
- Clear sweep length: with rst low from cycle 0, entries 0..DEPTH-1 are written in cycles 0..DEPTH-1, and ready=1 from cycle DEPTH onward.
- Write-to-read latency without forwarding: a write at edge k is visible on rdata in the cycle after edge k. During the write cycle itself, old data is returned.
- Read latency is 0 cycles, combinational from raddr.

## Configuration
- Macro: FPGA_RAM_BYPASS_EN.
- Defined:
  - In RUN, if we=1, waddr<DEPTH and raddr[i]==waddr, then rdata[i]=wdata in the same cycle, for every matching port.
  - Adds one comparator and mux per read port.
- Undefined: the same case returns the pre-write mem contents.
- In INIT, forwarding is disabled in both builds and rdata stays 0.

## Structure
- Shared package fpga_ram_pkg holds:
  - the state enum (RAM_INIT, RAM_RUN);
  - the helper function computing ADDR_W with a floor of 1.
- Sub-module fpga_ram_1r1w holds one LUTRAM bank: clk, we, waddr, wdata, raddr, rdata, asynchronous read, no reset.
  - The top level instantiates NRD copies in a generate loop.
  - The top level muxes the write port between the sweep (addr=clr_cnt, data=0, we=1) and the external port.
- The top level holds the FSM, clr_cnt, range checks, forwarding and output forcing.

## Test plan
- Reset/sweep, DEPTH=32, NRD=3: pulse rst for 2 cycles, hold we=1 with waddr=5, wdata=0xFFFF_FFFF throughout.
  - ready rises exactly 32 cycles after rst falls.
  - Reading all addresses then returns 0 on every port; the write during INIT was dropped.
- Basic write/read, in RUN: write 0xDEAD_BEEF at address 7.
  - Next cycle, raddr={7,7,3} gives rdata={0xDEAD_BEEF, 0xDEAD_BEEF, 0}.
- Same-cycle collision: we=1, waddr=9, wdata=0x1234, raddr[0]=9, with mem[9]=0x55.
  - FPGA_RAM_BYPASS_EN defined: rdata[0]=0x1234 in that cycle.
  - Undefined: rdata[0]=0x55.
  - Both builds: rdata[0]=0x1234 in the next cycle.
- Non-power-of-two, DEPTH=20, WIDTH=7:
  - The sweep takes 20 cycles.
  - A write to address 25 is ignored.
  - A read of address 25 returns 0.
  - Address 19 is writable and readable.
- Reset mid-operation: fill entries with nonzero data, assert rst in RUN for 1 cycle.
  - ready=0 next cycle.
  - After DEPTH further cycles, ready=1 and all entries read 0.
- Random regression: 10k cycles of random we/waddr/wdata/raddr against a reference model, with NRD=1, 3 and 5, in both macro builds.
